// File: rtl/phase_pkg.sv
// Shared types and constants for the phase_capture block.
// Optional feature macro: PHASE_AVG_EN (4-entry averaging of captures).
package phase_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2
   } phase_state_e;

   localparam int unsigned PHASE_W_DEF = 12;
   localparam int unsigned AVG_DEPTH   = 4;
   localparam int unsigned AVG_IDX_W   = 2;

endpackage : phase_pkg

// File: rtl/phase_capture_edge_sync.sv
// Multi-stage synchroniser for an asynchronous input followed by a
// rising-edge detector; the pulse is one clk wide.
module edge_sync
   import phase_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // synchroniser chain plus one history register for edge detection
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule : edge_sync

// File: rtl/phase_capture.sv
// Measures clk cycles from a reference rising edge to the next sensor rising edge.
// Optional macro PHASE_AVG_EN: phase_out becomes the mean of the last 4 captures.
module phase_capture
   import phase_pkg::*;
#(
   parameter int unsigned PHASE_W     = PHASE_W_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               ref_in,
   input  logic               sig_in,
   output logic [PHASE_W-1:0] phase_out,
   output logic               phase_valid,
   output logic               overflow
);

   localparam logic [PHASE_W-1:0] CNT_MAX = '1;
   localparam logic [PHASE_W-1:0] CNT_ONE = {{(PHASE_W-1){1'b0}}, 1'b1};

   logic               ref_rise_s;
   logic               sig_rise_s;
   phase_state_e       state_q, state_d;
   logic [PHASE_W-1:0] cnt_q, cnt_d;
   logic               cap_s;
   logic               sat_s;
   logic [PHASE_W-1:0] cap_val_s;
   logic [PHASE_W-1:0] result_s;
   logic [PHASE_W-1:0] phase_q;
   logic               valid_q;
   logic               ovf_q;

   edge_sync #(.STAGES(SYNC_STAGES)) u_ref_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (ref_in),
      .rise_o  (ref_rise_s)
   );

   edge_sync #(.STAGES(SYNC_STAGES)) u_sig_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (sig_in),
      .rise_o  (sig_rise_s)
   );

   // FSM state and interval counter
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state, counter and capture decision
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cap_s     = 1'b0;
      sat_s     = 1'b0;
      cap_val_s = '0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ARM;
               cnt_d   = '0;
            end
            ARM: begin
               if (ref_rise_s && sig_rise_s) begin
                  cap_s     = 1'b1;
                  cap_val_s = '0;
               end else if (ref_rise_s) begin
                  state_d = COUNT;
                  cnt_d   = CNT_ONE;
               end else begin
                  state_d = ARM;
               end
            end
            COUNT: begin
               // a sensor edge wins over saturation and over a new reference edge
               if (sig_rise_s || (cnt_q == CNT_MAX)) begin
                  cap_s     = 1'b1;
                  cap_val_s = cnt_q;
                  sat_s     = ~sig_rise_s;
                  if (ref_rise_s) begin
                     cnt_d = CNT_ONE;
                  end else begin
                     state_d = ARM;
                     cnt_d   = '0;
                  end
               end else if (ref_rise_s) begin
                  cnt_d = CNT_ONE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

`ifdef PHASE_AVG_EN
   logic [PHASE_W-1:0]   hist_q [AVG_DEPTH];
   logic [AVG_IDX_W-1:0] idx_q;
   logic [PHASE_W+1:0]   sum_q, sum_d;

   // running sum: drop the oldest entry, add the new capture
   always_comb begin
      sum_d    = sum_q - {2'b00, hist_q[idx_q]} + {2'b00, cap_val_s};
      result_s = sum_d[PHASE_W+1:2];
   end

   // history ring; cleared on reset and whenever the block is disabled
   always_ff @(posedge clk) begin
      if (!reset_n || !enable) begin
         for (int i = 0; i < int'(AVG_DEPTH); i++) begin
            hist_q[i] <= '0;
         end
         idx_q <= '0;
         sum_q <= '0;
      end else if (cap_s) begin
         hist_q[idx_q] <= cap_val_s;
         idx_q         <= idx_q + {{(AVG_IDX_W-1){1'b0}}, 1'b1};
         sum_q         <= sum_d;
      end else begin
         sum_q <= sum_q;
      end
   end
`else
   assign result_s = cap_val_s;
`endif

   // output registers; phase_out only changes on a capture
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         phase_q <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= cap_s;
         if (cap_s) begin
            phase_q <= result_s;
            ovf_q   <= sat_s;
         end else begin
            phase_q <= phase_q;
            ovf_q   <= ovf_q;
         end
      end
   end

   assign phase_out   = phase_q;
   assign phase_valid = valid_q;
   assign overflow    = ovf_q;

endmodule : phase_capture

// File: tb/tb_phase_capture.sv
// Directed self-checking bench for phase_capture (default build, averaging off).
module tb_phase_capture;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        ref_in;
   logic        sig_in;
   logic [11:0] phase_out;
   logic        phase_valid;
   logic        overflow;

   int tests_run    = 0;
   int tests_failed = 0;
   int valid_cnt    = 0;
   int base;
   logic found;

   phase_capture #(.PHASE_W(12), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .ref_in      (ref_in),
      .sig_in      (sig_in),
      .phase_out   (phase_out),
      .phase_valid (phase_valid),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (phase_valid === 1'b1) valid_cnt <= valid_cnt + 1;
   end

   task automatic check(input string tag, input int obs, input int exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int max_cycles, output logic hit);
      hit = 1'b0;
      for (int i = 0; i < max_cycles && !hit; i++) begin
         @(negedge clk);
         if (phase_valid === 1'b1) hit = 1'b1;
      end
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b0; ref_in = 1'b0; sig_in = 1'b0;
      cyc(5);
      check("rst_phase", int'(phase_out), 0);
      check("rst_valid", int'(phase_valid), 0);
      check("rst_ovf", int'(overflow), 0);
      reset_n = 1'b1;

      // disabled: edges must be ignored
      for (int k = 0; k < 4; k++) begin
         ref_in = 1'b1; cyc(6); sig_in = 1'b1; cyc(6);
         ref_in = 1'b0; sig_in = 1'b0; cyc(6);
      end
      check("idle_valid_cnt", valid_cnt, 0);
      check("idle_phase", int'(phase_out), 0);
      check("idle_ovf", int'(overflow), 0);

      // nominal 100-cycle delay
      enable = 1'b1; cyc(5);
      base = valid_cnt;
      ref_in = 1'b1; cyc(100); sig_in = 1'b1;
      wait_valid(20, found);
      check("nom_found", int'(found), 1);
      check("nom_phase", int'(phase_out), 100);
      check("nom_ovf", int'(overflow), 0);
      @(negedge clk);
      check("nom_pulse_width", int'(phase_valid), 0);
      cyc(5);
      check("nom_pulses", valid_cnt - base, 1);
      ref_in = 1'b0; sig_in = 1'b0; cyc(10);

      // coincident edges then 1-cycle delay
      ref_in = 1'b1; sig_in = 1'b1;
      wait_valid(20, found);
      check("coin_found", int'(found), 1);
      check("coin_phase", int'(phase_out), 0);
      ref_in = 1'b0; sig_in = 1'b0; cyc(10);
      ref_in = 1'b1; cyc(1); sig_in = 1'b1;
      wait_valid(20, found);
      check("one_found", int'(found), 1);
      check("one_phase", int'(phase_out), 1);
      ref_in = 1'b0; sig_in = 1'b0; cyc(10);

      // saturation, then late sensor edge ignored, then recovery
      ref_in = 1'b1;
      wait_valid(4200, found);
      check("sat_found", int'(found), 1);
      check("sat_phase", int'(phase_out), 4095);
      check("sat_ovf", int'(overflow), 1);
      cyc(900);
      base = valid_cnt;
      sig_in = 1'b1; cyc(10);
      check("sat_late_sig", valid_cnt - base, 0);
      check("sat_hold", int'(phase_out), 4095);
      ref_in = 1'b0; sig_in = 1'b0; cyc(10);
      ref_in = 1'b1; cyc(20); sig_in = 1'b1;
      wait_valid(20, found);
      check("rec_found", int'(found), 1);
      check("rec_phase", int'(phase_out), 20);
      check("rec_ovf", int'(overflow), 0);
      ref_in = 1'b0; sig_in = 1'b0; cyc(10);

      // missed sensor edge: second reference edge restarts timing
      base = valid_cnt;
      ref_in = 1'b1; cyc(50); ref_in = 1'b0; cyc(50);
      ref_in = 1'b1; cyc(30); sig_in = 1'b1;
      wait_valid(20, found);
      check("miss_found", int'(found), 1);
      check("miss_phase", int'(phase_out), 30);
      cyc(5);
      check("miss_pulses", valid_cnt - base, 1);
      ref_in = 1'b0; sig_in = 1'b0; cyc(10);

      // abort by enable low mid-count
      base = valid_cnt;
      ref_in = 1'b1; cyc(40); enable = 1'b0; cyc(5);
      sig_in = 1'b1; cyc(20);
      check("abort_pulses", valid_cnt - base, 0);
      check("abort_phase", int'(phase_out), 30);
      ref_in = 1'b0; sig_in = 1'b0; cyc(5);
      enable = 1'b1; cyc(5);
      ref_in = 1'b1; cyc(7); sig_in = 1'b1;
      wait_valid(20, found);
      check("reen_found", int'(found), 1);
      check("reen_phase", int'(phase_out), 7);
      ref_in = 1'b0; sig_in = 1'b0; cyc(10);

      // reset during a measurement
      ref_in = 1'b1; cyc(15);
      reset_n = 1'b0; cyc(2);
      check("mid_rst_phase", int'(phase_out), 0);
      check("mid_rst_valid", int'(phase_valid), 0);
      base = valid_cnt;
      ref_in = 1'b0; sig_in = 1'b1; cyc(5);
      sig_in = 1'b0; cyc(5);
      reset_n = 1'b1; cyc(10);
      check("mid_rst_pulses", valid_cnt - base, 0);
      check("mid_rst_hold", int'(phase_out), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_phase_capture

// File: doc/phase_capture.md
# phase_capture

Measures the phase delay, in `clk` cycles, between a rising edge on the reference input and the next rising edge on the sensor input. It produces a 12-bit result that drives the `in_port` of the phase PIO read by the HPS over Avalon. The block sits directly upstream of that PIO. It synchronises both asynchronous inputs, times the interval with a saturating counter, and holds the last result stable until the next measurement completes.

## Interface
- `PHASE_W`, 12: result and counter width; matches the PIO port width.
- `SYNC_STAGES`, 2: flip-flop stages in each input synchroniser; minimum 2.
- `clk`  in  1: system clock; the only clock in the block.
- `reset_n`  in  1: reset, **synchronous, active-low**.
- `enable`  in  1: when low, measurement stops; outputs hold.
- `ref_in`  in  1: asynchronous reference signal.
- `sig_in`  in  1: asynchronous sensor signal.
- `phase_out`  out  PHASE_W: last measured phase; connects to PIO `in_port`.
- `phase_valid`  out  1: one-cycle pulse when `phase_out` updates.
- `overflow`  out  1: last measurement saturated.

## Operation
- Each input passes through a `SYNC_STAGES` synchroniser plus one edge register.
  - `ref_rise` / `sig_rise` = synchronised value high and previous value low.
- FSM states:
  - **IDLE**: entered on reset or when `enable` is low. Counter is held at 0.
  - **ARM**: waits for `ref_rise`.
  - **COUNT**: times the interval.
- Transitions:
  - IDLE → ARM when `enable` = 1.
  - ARM → COUNT on `ref_rise`; counter loads 1.
  - ARM with `ref_rise` and `sig_rise` in the same cycle: capture 0 and stay in ARM.
  - COUNT, `sig_rise` in cycle N: capture the counter value and go to ARM. The counter increments by 1 every COUNT cycle.
  - COUNT, `ref_rise` without `sig_rise`: counter reloads 1 and stays in COUNT. This is a missed sensor edge; nothing is captured.
  - COUNT, `ref_rise` and `sig_rise` together: capture the counter value (the `sig_rise` wins), then reload 1 and stay in COUNT.
  - COUNT, counter = 2^PHASE_W−1 with no `sig_rise`: capture 2^PHASE_W−1, set `overflow`, go to ARM. The counter never wraps.
  - Any state with `enable` = 0: go to IDLE. An in-flight count is discarded and outputs hold their values.
- Capture rules:
  - `phase_out` registers the captured value and `phase_valid` pulses.
  - `overflow` is set only by a saturated capture and is cleared by the next non-saturated capture.
- Reset mid-measurement: all state clears on the next `clk` edge. No capture occurs.

## Timing
- Reset values: `phase_out` = 0, `phase_valid` = 0, `overflow` = 0, FSM = IDLE, synchronisers = 0.
- Input-to-detect latency: `SYNC_STAGES` + 1 cycles for both inputs. Equal latency on both inputs means the measured phase is unbiased.
- Result value: number of `clk` cycles between the detected `ref_rise` and the detected `sig_rise`.
- Capture-to-output: `phase_out` and `phase_valid` assert in cycle N+1 when the capture occurs in cycle N.
- `phase_out` is constant between `phase_valid` pulses. It is safe for the PIO's free-running read register.
- Pulses narrower than one `clk` period may be missed; this is not detected.

## Configuration
- `PHASE_AVG_EN` defined:
  - `phase_out` is the mean of the last 4 captures, computed as a PHASE_W+2-bit running sum of a 4-entry history, shifted right by 2 (truncating).
  - The history clears to 0 on reset and when entering IDLE.
  - The first 3 results after clear average with those zeros.
  - Saturated captures enter the history as 2^PHASE_W−1.
  - Adds 0 cycles of extra latency: the sum is updated in the capture cycle.
- `PHASE_AVG_EN` undefined: `phase_out` is the raw capture; no history logic is present.

## Structure
- Package `phase_pkg`:
  - FSM state enum (`IDLE`, `ARM`, `COUNT`).
  - Default width constant `PHASE_W_DEF` = 12.
  - Constant `AVG_DEPTH` = 4.
- Sub-module `edge_sync`:
  - Parameterised synchroniser plus rising-edge detector.
  - Instantiated once for `ref_in` and once for `sig_in`.

## Test plan
- **Reset and idle:** hold `reset_n` low 5 cycles, then `enable` = 0 with edges toggling on both inputs → all outputs 0, no `phase_valid`.
- **Nominal delay:** `enable` = 1, `sig_in` rises 100 `clk` cycles after `ref_in` → `phase_out` = 100, `phase_valid` pulses once, `overflow` = 0.
- **Coincident edges:** `ref_in` and `sig_in` rise on the same edge → `phase_out` = 0. Then a delay of 1 cycle → `phase_out` = 1.
- **Saturation:** `ref_in` rises, `sig_in` stays low for 5000 cycles → `phase_out` = 4095, `overflow` = 1. The next delay of 20 cycles → `phase_out` = 20, `overflow` = 0.
- **Missed edge and abort:**
  - `ref_in` rises twice (100 cycles apart) before `sig_in` rises 30 cycles after the second → `phase_out` = 30.
  - `enable` drops mid-COUNT → no `phase_valid`, `phase_out` unchanged.
- **Averaging (`PHASE_AVG_EN`):** captures of 40, 80, 120, 160 → `phase_out` = 10, 30, 60, 100.
